alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 171 +++++++++++++++++
 tb/tb_alu_pipe.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Pipelined ALU: 1-cycle arith/logic/shift, optional shift-add multiplier under ALU_PIPE_MUL_EN.
// Latency 1 (multiply MUL_CYCLES+1); result held while out_ready=0, G=0 freezes everything.
module alu_pipe #(
    parameter int WIDTH      = 8,
    parameter int MUL_CYCLES = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             G,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       O,
    input  logic [2:0]       S,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] F,
    output logic             C2,
    output logic             Z,
    output logic             ERR
);
    typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;
    state_t state;

    logic             accept;
    logic [WIDTH-1:0] res_f;
    logic             res_c;
    logic             res_err;
    logic [WIDTH:0]   a_x, b_x, c_x, one_x, ext;

    // in_ready is also gated by rst so it drops the instant reset asserts
    assign in_ready = rst & G & (state == IDLE) & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;

    assign a_x   = {1'b0, A};
    assign b_x   = {1'b0, B};
    assign c_x   = {{WIDTH{1'b0}}, C1};
    assign one_x = (WIDTH+1)'(1);

    always_comb begin
        res_f   = '0;
        res_c   = 1'b0;
        res_err = 1'b0;
        ext     = '0;
        case (O)
            2'b00: begin
                // bit WIDTH of the extended result is carry for adds, borrow for subtracts
                case (S)
                    3'd0: ext = a_x + b_x;
                    3'd1: ext = a_x + b_x + c_x;
                    3'd2: ext = a_x - b_x;
                    3'd3: ext = a_x - b_x - c_x;
                    3'd4: ext = a_x + one_x;
                    3'd5: ext = a_x - one_x;
                    3'd6: ext = a_x;
                    default: ext = '0 - a_x;
                endcase
                res_f = ext[WIDTH-1:0];
                res_c = ext[WIDTH];
            end
            2'b01: begin
                case (S)
                    3'd0: res_f = A & B;
                    3'd1: res_f = A | B;
                    3'd2: res_f = A ^ B;
                    3'd3: res_f = ~(A & B);
                    3'd4: res_f = ~(A | B);
                    3'd5: res_f = ~(A ^ B);
                    3'd6: res_f = ~A;
                    default: res_f = B;
                endcase
            end
            2'b10: begin
                case (S)
                    3'd0: begin res_f = {A[WIDTH-2:0], 1'b0};      res_c = A[WIDTH-1]; end
                    3'd1: begin res_f = {1'b0, A[WIDTH-1:1]};      res_c = A[0];       end
                    3'd2: begin res_f = {A[WIDTH-1], A[WIDTH-1:1]}; res_c = A[0];      end
                    3'd3: res_f = {A[WIDTH-2:0], A[WIDTH-1]};
                    3'd4: res_f = {A[0], A[WIDTH-1:1]};
                    3'd5: begin res_f = {A[WIDTH-2:0], C1};        res_c = A[WIDTH-1]; end
                    3'd6: begin res_f = {C1, A[WIDTH-1:1]};        res_c = A[0];       end
                    default: res_f = {A[WIDTH/2-1:0], A[WIDTH-1:WIDTH/2]};
                endcase
            end
            default: res_err = 1'b1;
        endcase
    end

`ifdef ALU_PIPE_MUL_EN
    localparam int CW = $clog2(MUL_CYCLES + 1);

    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] prod, mcand, prod_nxt;
    logic [WIDTH-1:0]   mplier, mul_f;
    logic               hi_sel;

    assign prod_nxt = mplier[0] ? prod + mcand : prod;
    assign mul_f    = hi_sel ? prod_nxt[2*WIDTH-1:WIDTH] : prod_nxt[WIDTH-1:0];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            F         <= '0;
            C2        <= 1'b0;
            Z         <= 1'b0;
            ERR       <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
            cnt       <= '0;
            prod      <= '0;
            mcand     <= '0;
            mplier    <= '0;
            hi_sel    <= 1'b0;
`endif
        end else if (G) begin
            case (state)
                IDLE: begin
                    if (accept) begin
`ifdef ALU_PIPE_MUL_EN
                        if (O == 2'b11 && S[2:1] == 2'b00) begin
                            // F keeps the previous value until the product is ready
                            state     <= MUL;
                            out_valid <= 1'b0;
                            cnt       <= '0;
                            prod      <= '0;
                            mcand     <= {{WIDTH{1'b0}}, A};
                            mplier    <= B;
                            hi_sel    <= S[0];
                        end else
`endif
                        begin
                            out_valid <= 1'b1;
                            F         <= res_f;
                            C2        <= res_c;
                            Z         <= (res_f == '0);
                            ERR       <= res_err;
                        end
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
`ifdef ALU_PIPE_MUL_EN
                MUL: begin
                    prod   <= prod_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(MUL_CYCLES - 1)) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        F         <= mul_f;
                        C2        <= |prod_nxt[2*WIDTH-1:WIDTH];
                        Z         <= (mul_f == '0);
                        ERR       <= 1'b0;
                    end
                end
`endif
                HOLD: begin
                    if (out_valid && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (WIDTH=8): vector table plus reset, backpressure, enable and multiply sequences.
module tb_alu_pipe;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, G, in_valid, in_ready, C1, out_valid, out_ready, C2, Z, ERR;
    logic [1:0]   O;
    logic [2:0]   S;
    logic [W-1:0] A, B, F;

    int checks = 0;
    int errors = 0;

    alu_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .G(G), .in_valid(in_valid), .in_ready(in_ready),
        .O(O), .S(S), .A(A), .B(B), .C1(C1),
        .out_valid(out_valid), .out_ready(out_ready),
        .F(F), .C2(C2), .Z(Z), .ERR(ERR)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   o;
        logic [2:0]   s;
        logic [W-1:0] a, b;
        logic         c1;
        logic [W-1:0] f;
        logic         c2, z, err;
    } vec_t;

    localparam int NV = 25;
    vec_t vec[NV];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [1:0] o, input logic [2:0] s, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic c1);
        O = o; S = s; A = a; B = b; C1 = c1;
    endtask

    task automatic chk_zero(input string tag);
        chk1({tag, "_vld"}, out_valid, 1'b0);
        chk8({tag, "_f"},   F,         8'h00);
        chk1({tag, "_c2"},  C2,        1'b0);
        chk1({tag, "_z"},   Z,         1'b0);
        chk1({tag, "_err"}, ERR,       1'b0);
        chk1({tag, "_rdy"}, in_ready,  1'b0);
    endtask

`ifdef ALU_PIPE_MUL_EN
    // lat counts edges from the accept edge (inclusive) to the edge that raises out_valid
    task automatic mul_run(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int freeze_at, input int freeze_len, output int lat);
        set_op(2'b11, s, a, b, 1'b0);
        in_valid = 1'b1; out_ready = 1'b1; G = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            chk1("mul_busy_rdy", in_ready, 1'b0);
            G = (lat >= freeze_at && lat < freeze_at + freeze_len) ? 1'b0 : 1'b1;
            tick();
            lat++;
        end
        G = 1'b1;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        int lat, seen;
        vec[0]  = '{2'b00, 3'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        vec[1]  = '{2'b00, 3'd1, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, 1'b0};
        vec[2]  = '{2'b00, 3'd2, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0, 1'b0};
        vec[3]  = '{2'b00, 3'd3, 8'h50, 8'h20, 1'b1, 8'h2F, 1'b0, 1'b0, 1'b0};
        vec[4]  = '{2'b00, 3'd4, 8'h7F, 8'h00, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0};
        vec[5]  = '{2'b00, 3'd5, 8'h00, 8'h00, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
        vec[6]  = '{2'b00, 3'd6, 8'h5A, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0};
        vec[7]  = '{2'b00, 3'd7, 8'h01, 8'h00, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
        vec[8]  = '{2'b01, 3'd0, 8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0, 1'b0, 1'b0};
        vec[9]  = '{2'b01, 3'd1, 8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
        vec[10] = '{2'b01, 3'd2, 8'hAA, 8'hAA, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        vec[11] = '{2'b01, 3'd3, 8'hF0, 8'h3C, 1'b0, 8'hCF, 1'b0, 1'b0, 1'b0};
        vec[12] = '{2'b01, 3'd4, 8'hF0, 8'h0C, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0};
        vec[13] = '{2'b01, 3'd5, 8'hA5, 8'h0F, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0};
        vec[14] = '{2'b01, 3'd6, 8'h00, 8'h77, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
        vec[15] = '{2'b01, 3'd7, 8'hFF, 8'h3C, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0};
        vec[16] = '{2'b10, 3'd0, 8'h81, 8'h00, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0};
        vec[17] = '{2'b10, 3'd1, 8'h81, 8'h00, 1'b0, 8'h40, 1'b1, 1'b0, 1'b0};
        vec[18] = '{2'b10, 3'd2, 8'h82, 8'h00, 1'b0, 8'hC1, 1'b0, 1'b0, 1'b0};
        vec[19] = '{2'b10, 3'd3, 8'h81, 8'h00, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0};
        vec[20] = '{2'b10, 3'd4, 8'h81, 8'h00, 1'b0, 8'hC0, 1'b0, 1'b0, 1'b0};
        vec[21] = '{2'b10, 3'd5, 8'h80, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        vec[22] = '{2'b10, 3'd6, 8'h01, 8'h00, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0};
        vec[23] = '{2'b11, 3'd2, 8'h12, 8'h34, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
        vec[24] = '{2'b10, 3'd7, 8'hA5, 8'h00, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0};

        // reset state, then first accept on the first edge after release
        rst = 1'b0; G = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        set_op(2'b00, 3'd4, 8'h41, 8'h00, 1'b0);
        #2;
        chk_zero("reset");
        #5 rst = 1'b1;
        #1 chk1("first_rdy", in_ready, 1'b1);
        tick();
        chk1("first_vld", out_valid, 1'b1);
        chk8("first_f", F, 8'h42);

        // back-to-back vectors: consumer always ready, so each edge replaces the result
        for (int i = 0; i < NV; i++) begin
            set_op(vec[i].o, vec[i].s, vec[i].a, vec[i].b, vec[i].c1);
            #1 chk1($sformatf("v%0d_rdy", i), in_ready, 1'b1);
            tick();
            chk1($sformatf("v%0d_vld", i), out_valid, 1'b1);
            chk8($sformatf("v%0d_f", i), F, vec[i].f);
            chk1($sformatf("v%0d_c2", i), C2, vec[i].c2);
            chk1($sformatf("v%0d_z", i), Z, vec[i].z);
            chk1($sformatf("v%0d_err", i), ERR, vec[i].err);
        end

        // backpressure: result held, no accept for three cycles
        out_ready = 1'b0;
        set_op(2'b01, 3'd6, 8'h00, 8'h00, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1 chk1("bp_rdy", in_ready, 1'b0);
            tick();
            chk1("bp_vld", out_valid, 1'b1);
            chk8("bp_f", F, 8'h5A);
            chk1("bp_c2", C2, 1'b0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk1("drain_vld", out_valid, 1'b0);
        chk8("drain_f", F, 8'h5A);

        // G=0 freezes a pending result and blocks accepts
        set_op(2'b00, 3'd6, 8'h33, 8'h00, 1'b0);
        in_valid = 1'b1;
        tick();
        chk8("g_pre_f", F, 8'h33);
        G = 1'b0;
        set_op(2'b01, 3'd6, 8'h0F, 8'h00, 1'b0);
        #1 chk1("g_rdy", in_ready, 1'b0);
        tick();
        chk1("g_vld", out_valid, 1'b1);
        chk8("g_f", F, 8'h33);
        G = 1'b1;
        tick();
        chk8("g_resume_f", F, 8'hF0);
        in_valid = 1'b0;
        tick();

        // asynchronous reset with a pending result clears outputs at once
        set_op(2'b00, 3'd7, 8'h01, 8'h00, 1'b0);
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        chk8("rst_pre_f", F, 8'hFF);
        #2 rst = 1'b0;
        #1 chk_zero("rst_async");
        #2 rst = 1'b1;
        out_ready = 1'b1;
        tick();
        chk1("rst_after_vld", out_valid, 1'b0);

`ifdef ALU_PIPE_MUL_EN
        mul_run(3'd0, 8'h0F, 8'h11, 1000, 0, lat);
        chki("mul_lo_lat", lat, 9);
        chk8("mul_lo_f", F, 8'hFF);
        chk1("mul_lo_c2", C2, 1'b0);
        chk1("mul_lo_err", ERR, 1'b0);
        tick();
        chk1("mul_lo_drop", out_valid, 1'b0);

        mul_run(3'd1, 8'h0F, 8'h11, 1000, 0, lat);
        chki("mul_hi_lat", lat, 9);
        chk8("mul_hi_f", F, 8'h00);
        chk1("mul_hi_c2", C2, 1'b0);
        chk1("mul_hi_z", Z, 1'b1);
        tick();

        mul_run(3'd1, 8'hFF, 8'hFF, 3, 5, lat);
        chki("mul_frz_lat", lat, 14);
        chk8("mul_frz_f", F, 8'hFE);
        chk1("mul_frz_c2", C2, 1'b1);
        tick();

        // reset at iteration 4 abandons the multiply
        set_op(2'b00, 3'd6, 8'h5A, 8'h00, 1'b0);
        in_valid = 1'b1;
        tick();
        set_op(2'b11, 3'd0, 8'h0F, 8'h11, 1'b0);
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        #1 rst = 1'b0;
        #1 chk_zero("mul_rst");
        #2 rst = 1'b1;
        seen = 0;
        repeat (12) begin
            tick();
            if (out_valid) seen++;
        end
        chki("mul_rst_noresult", seen, 0);
`else
        set_op(2'b11, 3'd0, 8'h0F, 8'h11, 1'b0);
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk1("nomul_vld", out_valid, 1'b1);
        chk8("nomul_f", F, 8'h00);
        chk1("nomul_c2", C2, 1'b0);
        chk1("nomul_err", ERR, 1'b1);
        tick();
        chk1("nomul_drop", out_valid, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
